brg_multi: RTL and testbench

BRG_MULTI -- requirements
Module: brg_multi

---
 rtl/brg_multi.sv | 180 ++++++++++++++++++
 tb/tb_brg_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/brg_multi.sv
// rtl/brg_multi.sv - processor-to-multi-device register bridge with wait states and irq sync.
// Define BRG_IRQ_SYNC_EN for a two-flop irq synchroniser; otherwise a single register stage.
module brg_multi #(
    parameter int          NDEV = 3,
    parameter logic [29:0] BASE = 30'h1fc0,
    parameter int          WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prReq,
    input  logic [29:0]          prAddr,
    input  logic [31:0]          prWd,
    input  logic                 prWe,
    input  logic [3:0]           prBe,
    output logic [31:0]          prRd,
    output logic                 prReady,
    output logic [1:0]           devAddr,
    output logic [31:0]          devWd,
    output logic [3:0]           devBe,
    output logic [NDEV-1:0]      devSel,
    output logic [NDEV-1:0]      devWe,
    input  logic [NDEV*32-1:0]   devRd,
    input  logic [NDEV-1:0]      irq,
    output logic [5:0]           hwInt,
    output logic                 devClk,
    output logic                 devRst
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;

    localparam logic [29:0] SPAN   = 30'(4 * NDEV);
    localparam logic [3:0]  WAIT_C = 4'(WAIT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        idx_q, idx_d;
    logic [31:0]       rd_q, rd_d;
    logic [NDEV-1:0]   irq_s1_q, irq_s1_d;
    logic [NDEV-1:0]   irq_sync;

    logic [29:0]       offset;
    logic              mapped;
    logic [31:0]       rd_sel;
    logic [NDEV-1:0]   sel_vec;
    logic              last_acc;

    // BASE is aligned to the decode span, so the offset bits directly give the device index
    assign offset = prAddr - BASE;
    assign mapped = (prAddr >= BASE) && (offset < SPAN);

    always_comb begin
        rd_sel  = '0;
        sel_vec = '0;
        for (int k = 0; k < NDEV; k++) begin
            if (idx_q == 3'(k)) begin
                rd_sel     = devRd[32*k +: 32];
                sel_vec[k] = 1'b1;
            end
        end
    end

    assign last_acc = (state_q == S_ACC) && (cnt_q == WAIT_C);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        we_d    = we_q;
        be_d    = be_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (prReq) begin
                    addr_d = prAddr[1:0];
                    wd_d   = prWd;
                    we_d   = prWe;
                    be_d   = prBe;
                    idx_d  = offset[4:2];
                    cnt_d  = 4'd0;
                    if (mapped) begin
                        state_d = S_ACC;
                    end else begin
                        state_d = S_RESP;
                        rd_d    = '0;
                    end
                end
            end
            S_ACC: begin
                if (cnt_q == WAIT_C) begin
                    rd_d    = we_q ? 32'd0 : rd_sel;
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            be_q    <= be_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        irq_s1_d = irq;
    end

`ifdef BRG_IRQ_SYNC_EN
    logic [NDEV-1:0] irq_s2_q, irq_s2_d;

    always_comb begin
        irq_s2_d = irq_s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1_q <= '0;
            irq_s2_q <= '0;
        end else begin
            irq_s1_q <= irq_s1_d;
            irq_s2_q <= irq_s2_d;
        end
    end

    assign irq_sync = irq_s2_q;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1_q <= '0;
        end else begin
            irq_s1_q <= irq_s1_d;
        end
    end

    assign irq_sync = irq_s1_q;
`endif

    always_comb begin
        hwInt           = '0;
        hwInt[NDEV-1:0] = irq_sync;
    end

    assign prRd    = rd_q;
    assign prReady = (state_q == S_RESP);
    assign devAddr = addr_q;
    assign devWd   = wd_q;
    assign devBe   = be_q;
    assign devSel  = (state_q == S_ACC) ? sel_vec : '0;
    // write strobe only in the final access cycle, and suppressed for all-zero byte enables
    assign devWe   = (last_acc && we_q && (be_q != 4'd0)) ? sel_vec : '0;
    assign devClk  = clk;
    assign devRst  = rst;

endmodule

// File: tb/tb_brg_multi.sv
// tb/tb_brg_multi.sv - directed self-checking bench for brg_multi (WAIT=1 and WAIT=0 instances).
module tb_brg_multi;

    logic         clk = 1'b0;
    logic         rst;
    logic         prReq;
    logic [29:0]  prAddr;
    logic [31:0]  prWd;
    logic         prWe;
    logic [3:0]   prBe;
    logic [95:0]  devRd;
    logic [2:0]   irq;

    logic [31:0]  prRd0, prRd1;
    logic         prReady0, prReady1;
    logic [1:0]   devAddr0, devAddr1;
    logic [31:0]  devWd0, devWd1;
    logic [3:0]   devBe0, devBe1;
    logic [2:0]   devSel0, devSel1;
    logic [2:0]   devWe0, devWe1;
    logic [5:0]   hwInt0, hwInt1;
    logic         devClk0, devClk1, devRst0, devRst1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    brg_multi #(.NDEV(3), .BASE(30'h1fc0), .WAIT(1)) u0 (
        .clk(clk), .rst(rst), .prReq(prReq), .prAddr(prAddr), .prWd(prWd),
        .prWe(prWe), .prBe(prBe), .prRd(prRd0), .prReady(prReady0),
        .devAddr(devAddr0), .devWd(devWd0), .devBe(devBe0), .devSel(devSel0),
        .devWe(devWe0), .devRd(devRd), .irq(irq), .hwInt(hwInt0),
        .devClk(devClk0), .devRst(devRst0)
    );

    brg_multi #(.NDEV(3), .BASE(30'h1fc0), .WAIT(0)) u1 (
        .clk(clk), .rst(rst), .prReq(prReq), .prAddr(prAddr), .prWd(prWd),
        .prWe(prWe), .prBe(prBe), .prRd(prRd1), .prReady(prReady1),
        .devAddr(devAddr1), .devWd(devWd1), .devBe(devBe1), .devSel(devSel1),
        .devWe(devWe1), .devRd(devRd), .irq(irq), .hwInt(hwInt1),
        .devClk(devClk1), .devRst(devRst1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [29:0] a, input logic we, input logic [31:0] wd, input logic [3:0] be);
        prReq  = 1'b1;
        prAddr = a;
        prWe   = we;
        prWd   = wd;
        prBe   = be;
    endtask

    logic [2:0] b2b_ready;
    logic [2:0] b2b_sel [6];

    initial begin
        rst    = 1'b1;
        prReq  = 1'b0;
        prAddr = '0;
        prWd   = '0;
        prWe   = 1'b0;
        prBe   = '0;
        irq    = '0;
        devRd  = {32'h12345678, 32'haaaa5555, 32'h0badf00d};
        tick();
        tick();
        check("rst_ready", prReady0, 0);
        check("rst_prrd", prRd0, 0);
        check("rst_sel", devSel0, 0);
        check("rst_hwint", hwInt0, 0);
        check("devrst_copy", devRst0, 1);
        rst = 1'b0;
        tick();

        // write to device 1, register 1
        request(30'h1fc5, 1'b1, 32'hdeadbeef, 4'hf);
        tick();
        prReq = 1'b0;
        check("wr_sel_t1", devSel0, 3'b010);
        check("wr_we_t1", devWe0, 3'b000);
        check("wr_wd", devWd0, 32'hdeadbeef);
        check("wr_addr", devAddr0, 2'b01);
        check("wr_be", devBe0, 4'hf);
        check("wr_ready_t1", prReady0, 0);
        tick();
        check("wr_sel_t2", devSel0, 3'b010);
        check("wr_we_t2", devWe0, 3'b010);
        tick();
        check("wr_ready_t3", prReady0, 1);
        check("wr_prrd", prRd0, 0);
        check("wr_sel_t3", devSel0, 0);
        check("wr_we_t3", devWe0, 0);
        tick();
        check("wr_ready_t4", prReady0, 0);

        // read of device 2, register 2
        request(30'h1fca, 1'b0, 32'h0, 4'hf);
        tick();
        prReq = 1'b0;
        check("rd_sel_t1", devSel0, 3'b100);
        check("rd_addr", devAddr0, 2'b10);
        tick();
        check("rd_we_t2", devWe0, 0);
        check("rd_ready_t2", prReady0, 0);
        tick();
        check("rd_ready_t3", prReady0, 1);
        check("rd_prrd", prRd0, 32'h12345678);
        tick();
        check("rd_ready_t4", prReady0, 0);
        check("rd_hold1", prRd0, 32'h12345678);
        tick();
        check("rd_hold2", prRd0, 32'h12345678);

        // first unmapped word above the last device
        request(30'h1fcc, 1'b0, 32'h0, 4'hf);
        tick();
        prReq = 1'b0;
        check("unm_ready_t1", prReady0, 1);
        check("unm_prrd", prRd0, 0);
        check("unm_sel", devSel0, 0);
        tick();
        check("unm_ready_t2", prReady0, 0);
        check("unm_sel_t2", devSel0, 0);
        check("unm_we_t2", devWe0, 0);

        // unmapped write just below BASE
        request(30'h1fbf, 1'b1, 32'h11111111, 4'hf);
        tick();
        prReq = 1'b0;
        check("low_ready_t1", prReady0, 1);
        check("low_sel", devSel0, 0);
        check("low_we", devWe0, 0);
        tick();

        // last mapped word of device 2
        request(30'h1fcb, 1'b0, 32'h0, 4'hf);
        tick();
        prReq = 1'b0;
        check("top_sel", devSel0, 3'b100);
        check("top_addr", devAddr0, 2'b11);
        tick();
        tick();
        check("top_ready", prReady0, 1);
        check("top_prrd", prRd0, 32'h12345678);
        tick();

        // write with zero byte enables: no strobe
        request(30'h1fc1, 1'b1, 32'hcafef00d, 4'h0);
        tick();
        prReq = 1'b0;
        check("be0_sel", devSel0, 3'b001);
        tick();
        check("be0_we", devWe0, 0);
        tick();
        check("be0_ready", prReady0, 1);
        tick();

        // WAIT=0 instance, back-to-back reads with prReq held high
        b2b_ready = 3'b0;
        b2b_sel[0] = 3'b010; b2b_sel[1] = 3'b000; b2b_sel[2] = 3'b000;
        b2b_sel[3] = 3'b010; b2b_sel[4] = 3'b000; b2b_sel[5] = 3'b000;
        request(30'h1fc4, 1'b0, 32'h0, 4'hf);
        for (int i = 0; i < 6; i++) begin
            tick();
            b2b_ready[0] = (i == 1 || i == 4);
            check($sformatf("b2b_ready_%0d", i), prReady1, b2b_ready[0]);
            check($sformatf("b2b_sel_%0d", i), devSel1, b2b_sel[i]);
            if (i == 1 || i == 4)
                check($sformatf("b2b_prrd_%0d", i), prRd1, 32'haaaa5555);
        end
        prReq = 1'b0;
        tick();
        tick();
        tick();
        tick();

        // irq on device 2 only
        irq = 3'b100;
        tick();
`ifdef BRG_IRQ_SYNC_EN
        check("irq_t1", hwInt0, 6'b000000);
        tick();
`endif
        check("irq_lat", hwInt0, 6'b000100);
        tick();
        check("irq_hold", hwInt0, 6'b000100);

        // reset during ACC of a write
        request(30'h1fc0, 1'b1, 32'h55aa55aa, 4'hf);
        tick();
        check("ab_sel_pre", devSel0, 3'b001);
        rst = 1'b1;
        #1;
        check("ab_sel", devSel0, 0);
        check("ab_we", devWe0, 0);
        check("ab_ready", prReady0, 0);
        check("ab_prrd", prRd0, 0);
        check("ab_wd", devWd0, 0);
        check("ab_be", devBe0, 0);
        check("ab_addr", devAddr0, 0);
        check("ab_hwint", hwInt0, 0);
        prReq = 1'b0;
        irq   = 3'b000;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ab_we_%0d", i), devWe0, 0);
            check($sformatf("ab_rdy_%0d", i), prReady0, 0);
        end

        // normal read after the aborted access
        request(30'h1fc8, 1'b0, 32'h0, 4'hf);
        tick();
        prReq = 1'b0;
        check("post_sel", devSel0, 3'b100);
        tick();
        tick();
        check("post_ready", prReady0, 1);
        check("post_prrd", prRd0, 32'h12345678);
        tick();
        check("post_ready_end", prReady0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
